// File: rtl/sr_cmd_pkg.sv
// Shared types and default timing constants for the SR command sequencer.
// The state encoding is fixed at two bits so it can be compared against a downstream checker.
package sr_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRV_S = 2'd1,
        DRV_R = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam int DEB_CYCLES_DEF  = 4;
    localparam int HOLD_CYCLES_DEF = 2;
    localparam int CNT_W_DEF       = 4;

    function automatic logic rise_edge(input logic cur, input logic prev);
        return cur & ~prev;
    endfunction

endpackage

// File: rtl/sr_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer for one raw request level.
// The debounced output follows the synchronised level only after DEB_CYCLES consecutive disagreeing cycles.
module sr_debounce #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             sync1_r;
    logic             sync2_r;
    logic             deb_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchroniser chain and debounce counter; the counter restarts whenever the levels agree.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            deb_r   <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            sync1_r <= din;
            sync2_r <= sync1_r;
            if (sync2_r == deb_r) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (cnt_r == DEB_LAST) begin
                deb_r <= sync2_r;
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    assign dout = deb_r;

endmodule

// File: rtl/sr_cmd_seq.sv
// Command stage for level-sensitive SR cells: debounced requests become mutually exclusive,
// fixed-length s/r pulses separated by a gap, with a model of the bit the cell should hold.
module sr_cmd_seq
    import sr_cmd_pkg::*;
#(
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic set_req,
    input  logic clr_req,
    output logic s,
    output logic r,
    output logic busy,
    output logic conflict,
    output logic q_exp
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             deb_set_s, deb_clr_s;
    logic             deb_set_d_r, deb_clr_d_r;
    logic             pend_set_r, pend_clr_r;
    logic             pend_set_nxt_s, pend_clr_nxt_s;
    logic             take_set_s, take_clr_s;
    state_t           state_r, state_nxt_s;
    logic [CNT_W-1:0] hold_r, hold_nxt_s;
    logic             s_r, r_r, busy_r, conflict_r, q_exp_r;
    logic             s_nxt_s, r_nxt_s, conflict_nxt_s, q_exp_nxt_s;

    sr_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_set (
        .clk  (clk),
        .rst  (rst),
        .din  (set_req),
        .dout (deb_set_s)
    );

    sr_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_clr (
        .clk  (clk),
        .rst  (rst),
        .din  (clr_req),
        .dout (deb_clr_s)
    );

    // Next-state, drive and bookkeeping decisions; s/r are decided here so they leave as registers.
    always_comb begin
        state_nxt_s    = state_r;
        hold_nxt_s     = hold_r;
        s_nxt_s        = 1'b0;
        r_nxt_s        = 1'b0;
        conflict_nxt_s = 1'b0;
        q_exp_nxt_s    = q_exp_r;
        take_set_s     = 1'b0;
        take_clr_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (pend_set_r && pend_clr_r) begin
                    take_set_s     = 1'b1;
                    take_clr_s     = 1'b1;
                    conflict_nxt_s = 1'b1;
                end else if (pend_set_r) begin
                    take_set_s  = 1'b1;
                    state_nxt_s = DRV_S;
                    s_nxt_s     = 1'b1;
                    hold_nxt_s  = {CNT_W{1'b0}};
                end else if (pend_clr_r) begin
                    take_clr_s  = 1'b1;
                    state_nxt_s = DRV_R;
                    r_nxt_s     = 1'b1;
                    hold_nxt_s  = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            DRV_S, DRV_R: begin
                if (hold_r == HOLD_LAST) begin
                    state_nxt_s = GAP;
                    q_exp_nxt_s = (state_r == DRV_S);
                    hold_nxt_s  = {CNT_W{1'b0}};
                end else begin
                    s_nxt_s    = (state_r == DRV_S);
                    r_nxt_s    = (state_r == DRV_R);
                    hold_nxt_s = hold_r + CNT_ONE;
                end
            end
            GAP: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        // A fresh rising edge wins over a same-cycle service so no request is dropped.
        pend_set_nxt_s = (pend_set_r & ~take_set_s) | rise_edge(deb_set_s, deb_set_d_r);
        pend_clr_nxt_s = (pend_clr_r & ~take_clr_s) | rise_edge(deb_clr_s, deb_clr_d_r);
    end

    // All sequencer state and the registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_set_d_r <= 1'b0;
            deb_clr_d_r <= 1'b0;
            pend_set_r  <= 1'b0;
            pend_clr_r  <= 1'b0;
            state_r     <= IDLE;
            hold_r      <= {CNT_W{1'b0}};
            s_r         <= 1'b0;
            r_r         <= 1'b0;
            busy_r      <= 1'b0;
            conflict_r  <= 1'b0;
            q_exp_r     <= 1'b0;
        end else begin
            deb_set_d_r <= deb_set_s;
            deb_clr_d_r <= deb_clr_s;
            pend_set_r  <= pend_set_nxt_s;
            pend_clr_r  <= pend_clr_nxt_s;
            state_r     <= state_nxt_s;
            hold_r      <= hold_nxt_s;
            s_r         <= s_nxt_s;
            r_r         <= r_nxt_s;
            busy_r      <= (state_nxt_s != IDLE);
            conflict_r  <= conflict_nxt_s;
            q_exp_r     <= q_exp_nxt_s;
        end
    end

    assign s        = s_r;
    assign r        = r_r;
    assign busy     = busy_r;
    assign conflict = conflict_r;
    assign q_exp    = q_exp_r;

endmodule

// File: tb/tb_sr_cmd_seq.sv
// Directed bench for sr_cmd_seq (DEB_CYCLES=4, HOLD_CYCLES=2); edge e counts from the first
// rising edge that samples a new raw request level.
module tb_sr_cmd_seq;

    logic clk = 1'b0;
    logic rst, set_req, clr_req;
    logic s, r, busy, conflict, q_exp;
    int   tests = 0;
    int   fails = 0;

    sr_cmd_seq #(.DEB_CYCLES(4), .HOLD_CYCLES(2), .CNT_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .set_req  (set_req),
        .clr_req  (clr_req),
        .s        (s),
        .r        (r),
        .busy     (busy),
        .conflict (conflict),
        .q_exp    (q_exp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // The forbidden s=r=1 combination must never appear, including around reset.
    always @(negedge clk) begin
        tests++;
        assert ((s & r) !== 1'b1) else begin
            fails++;
            $error("FAIL s_and_r: observed s=%b r=%b expected not both 1", s, r);
        end
    end

    // One clean command: drive high after edge 8 and 9, GAP after edge 10, IDLE after 11.
    task automatic cmd(input logic is_set, input logic q_before, input string tag);
        logic drv;
        if (is_set) set_req = 1'b1; else clr_req = 1'b1;
        for (int e = 1; e <= 18; e++) begin
            tick();
            drv = (e == 8) || (e == 9);
            chk({tag, "_s"}, s, is_set & drv);
            chk({tag, "_r"}, r, ~is_set & drv);
            chk({tag, "_busy"}, busy, (e >= 8) && (e <= 10));
            chk({tag, "_conflict"}, conflict, 1'b0);
            chk({tag, "_q"}, q_exp, (e >= 10) ? is_set : q_before);
            if (e == 10) begin
                set_req = 1'b0;
                clr_req = 1'b0;
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        set_req = 1'b1;
        clr_req = 1'b0;

        // Reset held for three edges with a set request already present.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_s", s, 1'b0);
            chk("rst_r", r, 1'b0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_q", q_exp, 1'b0);
            chk("rst_conflict", conflict, 1'b0);
        end
        rst = 1'b0;
        cmd(1'b1, 1'b0, "reset_exit_set");

        // Clean set followed by clean clear.
        cmd(1'b1, 1'b1, "clean_set");
        cmd(1'b0, 1'b1, "clean_clr");

        // Queued: clear is captured (edge 9) while s is driven, served after GAP and one IDLE cycle.
        set_req = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            chk("queued_s", s, (e == 8) || (e == 9));
            chk("queued_r", r, (e == 12) || (e == 13));
            chk("queued_busy", busy, ((e >= 8) && (e <= 10)) || ((e >= 12) && (e <= 14)));
            chk("queued_q", q_exp, (e >= 10) && (e < 14));
            if (e == 2) clr_req = 1'b1;
            if (e == 10) set_req = 1'b0;
            if (e == 12) clr_req = 1'b0;
        end

        cmd(1'b1, 1'b0, "restore_set");

        // Glitch of three sampled cycles must not pass the debouncer.
        set_req = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            tick();
            if (e == 3) set_req = 1'b0;
            chk("glitch_s", s, 1'b0);
            chk("glitch_busy", busy, 1'b0);
            chk("glitch_q", q_exp, 1'b1);
        end

        // Simultaneous set and clear: single conflict pulse after edge 8, no drive.
        set_req = 1'b1;
        clr_req = 1'b1;
        for (int e = 1; e <= 18; e++) begin
            tick();
            chk("simul_conflict", conflict, e == 8);
            chk("simul_s", s, 1'b0);
            chk("simul_r", r, 1'b0);
            chk("simul_busy", busy, 1'b0);
            chk("simul_q", q_exp, 1'b1);
            if (e == 10) begin
                set_req = 1'b0;
                clr_req = 1'b0;
            end
        end

        // Reset during DRV_S with a clear already pending: drive, busy, q_exp and pending all drop.
        set_req = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            tick();
            if (e == 1) clr_req = 1'b1;
        end
        chk("midrst_pre_s", s, 1'b1);
        chk("midrst_pre_busy", busy, 1'b1);
        rst     = 1'b1;
        set_req = 1'b0;
        clr_req = 1'b0;
        tick();
        chk("midrst_s", s, 1'b0);
        chk("midrst_r", r, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_q", q_exp, 1'b0);
        rst = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            tick();
            chk("midrst_after_s", s, 1'b0);
            chk("midrst_after_r", r, 1'b0);
            chk("midrst_after_busy", busy, 1'b0);
            chk("midrst_after_q", q_exp, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
